// File: rtl/param_seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator: WIDTH-bit operands, CHUNK bits per clock, valid/ready in and out.
// Optional result statistics counters are enabled with `define COMPARATOR_STATS_EN.
module param_seq_magnitude_comparator #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             equal,
   output logic             greater,
   output logic             less
`ifdef COMPARATOR_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] cnt_equal,
   output logic [CNT_W-1:0] cnt_greater,
   output logic [CNT_W-1:0] cnt_less
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Signed operands become offset binary so the chunk compare stays unsigned.
   function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] v, input logic s);
      logic [WIDTH-1:0] r;
      r            = v;
      r[WIDTH-1]   = v[WIDTH-1] ^ s;
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             decided_q, decided_d, gt_q, gt_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [2:0]       res_q, res_d;   // {equal, greater, less}
   logic [CHUNK-1:0] chunk_a_s, chunk_b_s;
   logic             dec_s, gtn_s;

   // Select the chunk addressed by the current index.
   always_comb begin
      chunk_a_s = {CHUNK{1'b0}};
      chunk_b_s = {CHUNK{1'b0}};
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == IDX_W'(i)) begin
            chunk_a_s = a_q[i*CHUNK +: CHUNK];
            chunk_b_s = b_q[i*CHUNK +: CHUNK];
         end else begin
            chunk_a_s = chunk_a_s;
            chunk_b_s = chunk_b_s;
         end
      end
   end

   // First unequal chunk decides; later chunks cannot override it.
   always_comb begin
      dec_s = decided_q;
      gtn_s = gt_q;
      if (!decided_q && (chunk_a_s != chunk_b_s)) begin
         dec_s = 1'b1;
         gtn_s = (chunk_a_s > chunk_b_s);
      end else begin
         dec_s = decided_q;
         gtn_s = gt_q;
      end
   end

   // Next-state and output-register logic.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      idx_d       = idx_q;
      decided_d   = decided_q;
      gt_d        = gt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d        = to_offset(A, is_signed);
               b_d        = to_offset(B, is_signed);
               idx_d      = IDX_W'(NCHUNK - 1);
               decided_d  = 1'b0;
               gt_d       = 1'b0;
               in_ready_d = 1'b0;
               state_d    = S_CMP;
            end else begin
               in_ready_d = 1'b1;
            end
         end
         S_CMP: begin
            decided_d = dec_s;
            gt_d      = gtn_s;
            if (idx_q == {IDX_W{1'b0}}) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               res_d       = {!dec_s, dec_s & gtn_s, dec_s & !gtn_s};
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               res_d       = 3'b000;
               in_ready_d  = 1'b1;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            res_d       = 3'b000;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= {WIDTH{1'b0}};
         b_q         <= {WIDTH{1'b0}};
         idx_q       <= {IDX_W{1'b0}};
         decided_q   <= 1'b0;
         gt_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_q       <= 3'b000;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         idx_q       <= idx_d;
         decided_q   <= decided_d;
         gt_q        <= gt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign equal     = res_q[2];
   assign greater   = res_q[1];
   assign less      = res_q[0];

`ifdef COMPARATOR_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] cnt_eq_q, cnt_gt_q, cnt_lt_q;
   logic             out_hs_s;

   assign out_hs_s = out_valid_q & out_ready;

   // Saturating result counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_eq_q <= {CNT_W{1'b0}};
         cnt_gt_q <= {CNT_W{1'b0}};
         cnt_lt_q <= {CNT_W{1'b0}};
      end else if (stats_clr) begin
         cnt_eq_q <= {CNT_W{1'b0}};
         cnt_gt_q <= {CNT_W{1'b0}};
         cnt_lt_q <= {CNT_W{1'b0}};
      end else if (out_hs_s) begin
         cnt_eq_q <= res_q[2] ? sat_inc(cnt_eq_q) : cnt_eq_q;
         cnt_gt_q <= res_q[1] ? sat_inc(cnt_gt_q) : cnt_gt_q;
         cnt_lt_q <= res_q[0] ? sat_inc(cnt_lt_q) : cnt_lt_q;
      end else begin
         cnt_eq_q <= cnt_eq_q;
         cnt_gt_q <= cnt_gt_q;
         cnt_lt_q <= cnt_lt_q;
      end
   end

   assign cnt_equal   = cnt_eq_q;
   assign cnt_greater = cnt_gt_q;
   assign cnt_less    = cnt_lt_q;
`endif

endmodule
